// File: rtl/id_hazard_ctl.sv
// Hazard/sequencing controller beside ID: shadow EX/MEM/WB destinations, stall/flush, forwarding, halt drain.
// Define HAZARD_FWD_EN for forwarding (load-use stalls only); undefined, any RAW dependency stalls.
module id_hazard_ctl #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned DRAIN_CYCLES   = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2,
    input  logic                      i_id_rs1_used,
    input  logic                      i_id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rd,
    input  logic                      i_id_rd_wen,
    input  logic                      i_id_is_load,
    input  logic                      i_id_halt,
    input  logic                      i_ex_taken,
    output logic                      o_pc_en,
    output logic                      o_if_id_en,
    output logic                      o_if_id_flush,
    output logic                      o_id_ex_flush,
    output logic [1:0]                o_fwd_a_sel,
    output logic [1:0]                o_fwd_b_sel,
    output logic                      o_halted
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      wen;
    } dst_t;

    // The load flag is only ever consulted for the EX entry, so it is not carried further.
    dst_t             r_ex, r_mem, r_wb;
    logic             r_ex_load;
    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    dst_t w_ex_nxt;
    logic w_ex_load_nxt;
    logic w_use_a, w_use_b;
    logic w_a_ex, w_a_mem, w_a_wb, w_b_ex, w_b_mem, w_b_wb;
    logic w_load_use, w_any_dep, w_stall;
    logic w_pc_en, w_if_id_en, w_if_id_flush, w_id_ex_flush, w_halted;
    logic [1:0] w_fwd_a, w_fwd_b;

    function automatic logic hit(input logic used, input logic [REG_ADDR_WIDTH-1:0] rs,
                                 input dst_t s);
        return used && s.wen && (s.rd != '0) && (s.rd == rs);
    endfunction

    assign w_use_a = i_id_valid & i_id_rs1_used;
    assign w_use_b = i_id_valid & i_id_rs2_used;

    assign w_a_ex  = hit(w_use_a, i_id_rs1, r_ex);
    assign w_a_mem = hit(w_use_a, i_id_rs1, r_mem);
    assign w_a_wb  = hit(w_use_a, i_id_rs1, r_wb);
    assign w_b_ex  = hit(w_use_b, i_id_rs2, r_ex);
    assign w_b_mem = hit(w_use_b, i_id_rs2, r_mem);
    assign w_b_wb  = hit(w_use_b, i_id_rs2, r_wb);

    assign w_load_use = (w_a_ex | w_b_ex) & r_ex_load;
    assign w_any_dep  = w_a_ex | w_a_mem | w_a_wb | w_b_ex | w_b_mem | w_b_wb;

`ifdef HAZARD_FWD_EN
    assign w_stall = w_load_use;
    assign w_fwd_a = w_a_ex ? 2'b01 : w_a_mem ? 2'b10 : w_a_wb ? 2'b11 : 2'b00;
    assign w_fwd_b = w_b_ex ? 2'b01 : w_b_mem ? 2'b10 : w_b_wb ? 2'b11 : 2'b00;
`else
    // Without bypass paths every reader waits until its writer has retired from WB.
    assign w_stall = w_any_dep | w_load_use;
    assign w_fwd_a = 2'b00;
    assign w_fwd_b = 2'b00;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pc_en       = 1'b1;
        w_if_id_en    = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_halted      = 1'b0;
        case (r_state)
            StRun: begin
                if (i_ex_taken) begin
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                end else if (w_stall) begin
                    w_pc_en       = 1'b0;
                    w_if_id_en    = 1'b0;
                    w_id_ex_flush = 1'b1;
                end else if (i_id_valid && i_id_halt) begin
                    w_state_nxt   = StDrain;
                    w_cnt_nxt     = CNT_LOAD;
                    w_pc_en       = 1'b0;
                    w_if_id_en    = 1'b0;
                    w_if_id_flush = 1'b1;
                end
            end
            StDrain: begin
                w_pc_en       = 1'b0;
                w_if_id_en    = 1'b0;
                w_id_ex_flush = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = StHalted;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            StHalted: begin
                w_pc_en       = 1'b0;
                w_if_id_en    = 1'b0;
                w_id_ex_flush = 1'b1;
                w_halted      = 1'b1;
            end
            default: w_state_nxt = StRun;
        endcase
        // Outputs hold their idle values for as long as reset is asserted.
        if (!i_rst_n) begin
            w_pc_en       = 1'b1;
            w_if_id_en    = 1'b1;
            w_if_id_flush = 1'b0;
            w_id_ex_flush = 1'b0;
            w_halted      = 1'b0;
        end
    end

    always_comb begin
        w_ex_nxt      = '0;
        w_ex_load_nxt = 1'b0;
        if (i_id_valid && !w_id_ex_flush) begin
            // A halt enters EX as a bubble so it never claims a destination.
            w_ex_nxt.rd   = i_id_rd;
            w_ex_nxt.wen  = i_id_rd_wen & ~i_id_halt;
            w_ex_load_nxt = i_id_is_load & ~i_id_halt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex      <= '0;
            r_mem     <= '0;
            r_wb      <= '0;
            r_ex_load <= 1'b0;
            r_state   <= StRun;
            r_cnt     <= '0;
        end else begin
            r_ex      <= w_ex_nxt;
            r_mem     <= r_ex;
            r_wb      <= r_mem;
            r_ex_load <= w_ex_load_nxt;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign o_pc_en       = w_pc_en;
    assign o_if_id_en    = w_if_id_en;
    assign o_if_id_flush = w_if_id_flush;
    assign o_id_ex_flush = w_id_ex_flush;
    assign o_fwd_a_sel   = i_rst_n ? w_fwd_a : 2'b00;
    assign o_fwd_b_sel   = i_rst_n ? w_fwd_b : 2'b00;
    assign o_halted      = w_halted;

endmodule
